// File: rtl/audio_pkg.sv
// audio_pkg: constants and helpers shared by the audio output path.
// Holds the clock divider ratios and a signed saturation helper.
package audio_pkg;

    localparam int SCK_DIV_LOG2  = 4;
    localparam int MCLK_DIV_LOG2 = 2;

    // Clamp x to the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] x,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave voice with a frame-rate attack/release envelope.
// Ports: clk, rst (async, active-low), i_tick (frame start), i_div (half-period),
//        i_vol (target level), i_gate (note on), o_sample (signed voice output).
module tone_voice
    import audio_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int DIV_W        = 22,
    parameter int ATTACK_STEP  = 256,
    parameter int RELEASE_STEP = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_tick,
    input  logic [DIV_W-1:0]           i_div,
    input  logic [SAMPLE_W-2:0]        i_vol,
    input  logic                       i_gate,
    output logic signed [SAMPLE_W-1:0] o_sample
);

    localparam int EW = SAMPLE_W - 1;

    logic [DIV_W-1:0]           r_cnt;
    logic                       r_ph;
    logic [EW-1:0]              r_env;
    logic                       w_silent;
    logic [31:0]                w_up;
    logic [EW-1:0]              w_env_nxt;
    logic signed [SAMPLE_W-1:0] w_mag;

    // Dividers of 0 or 1 cannot describe a tone; such a voice is muted.
    assign w_silent = (i_div <= DIV_W'(1));
    // Wide sum so a large attack step cannot wrap past the target.
    assign w_up = 32'(r_env) + 32'(ATTACK_STEP);

    always_comb begin
        w_env_nxt = r_env;
        if (i_gate) begin
            if (r_env < i_vol) begin
                w_env_nxt = (w_up >= 32'(i_vol)) ? i_vol : w_up[EW-1:0];
            end else begin
                w_env_nxt = i_vol;
            end
        end else if (32'(r_env) > 32'(RELEASE_STEP)) begin
            w_env_nxt = r_env - EW'(RELEASE_STEP);
        end else begin
            w_env_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_ph  <= 1'b0;
            r_env <= '0;
        end else begin
            // >= rather than == so a shortened divider wraps at once.
            if (w_silent) begin
                r_cnt <= '0;
                r_ph  <= 1'b0;
            end else if (r_cnt >= i_div - DIV_W'(1)) begin
                r_cnt <= '0;
                r_ph  <= ~r_ph;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
            if (i_tick) begin
                r_env <= w_env_nxt;
            end
        end
    end

    assign w_mag    = {1'b0, r_env};
    assign o_sample = w_silent ? '0 : (r_ph ? w_mag : -w_mag);

endmodule

// File: rtl/poly_speaker.sv
// poly_speaker: mixes NUM_VOICES tone voices into a saturated stereo pair
// and serialises it as left-justified I2S.
// Ports: clk, rst (async, active-low); note_div/vol/gate/pan_left/pan_right
//        per-voice controls; audio_mclk/lrck/sck/sdin DAC pins; frame_tick.
module poly_speaker
    import audio_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_W     = 16,
    parameter int DIV_W        = 22,
    parameter int ATTACK_STEP  = 256,
    parameter int RELEASE_STEP = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_VOICES*DIV_W-1:0]        note_div,
    input  logic [NUM_VOICES*(SAMPLE_W-1)-1:0] vol,
    input  logic [NUM_VOICES-1:0]              gate,
    input  logic [NUM_VOICES-1:0]              pan_left,
    input  logic [NUM_VOICES-1:0]              pan_right,
    output logic                               audio_mclk,
    output logic                               audio_lrck,
    output logic                               audio_sck,
    output logic                               audio_sdin,
    output logic                               frame_tick
);

    localparam int FRAME = 32 * SAMPLE_W;
    localparam int HALF  = 16 * SAMPLE_W;
    localparam int FC_W  = $clog2(FRAME);
    localparam int SUM_W = SAMPLE_W + 3;

    logic [FC_W-1:0]            r_fc;
    logic [SAMPLE_W-1:0]        r_shl;
    logic [SAMPLE_W-1:0]        r_shr;
    logic                       w_tick;
    logic                       w_lrck;
    logic                       w_slot_end;
    logic signed [SAMPLE_W-1:0] w_vs [NUM_VOICES];
    logic signed [SUM_W-1:0]    w_sum_l;
    logic signed [SUM_W-1:0]    w_sum_r;
    logic [SAMPLE_W-1:0]        w_sat_l;
    logic [SAMPLE_W-1:0]        w_sat_r;

    // Gated by rst so every pin reads 0 while reset is held.
    assign w_tick     = rst & (r_fc == '0);
    assign w_lrck     = (r_fc >= FC_W'(HALF));
    assign w_slot_end = &r_fc[SCK_DIV_LOG2-1:0];

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        tone_voice #(
            .SAMPLE_W    (SAMPLE_W),
            .DIV_W       (DIV_W),
            .ATTACK_STEP (ATTACK_STEP),
            .RELEASE_STEP(RELEASE_STEP)
        ) u_voice (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_div   (note_div[g*DIV_W +: DIV_W]),
            .i_vol   (vol[g*(SAMPLE_W-1) +: SAMPLE_W-1]),
            .i_gate  (gate[g]),
            .o_sample(w_vs[g])
        );
    end

    always_comb begin
        w_sum_l = '0;
        w_sum_r = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (pan_left[i]) begin
                w_sum_l = w_sum_l + {{3{w_vs[i][SAMPLE_W-1]}}, w_vs[i]};
            end
            if (pan_right[i]) begin
                w_sum_r = w_sum_r + {{3{w_vs[i][SAMPLE_W-1]}}, w_vs[i]};
            end
        end
    end

    assign w_sat_l = SAMPLE_W'(sat_signed(32'(w_sum_l), SAMPLE_W));
    assign w_sat_r = SAMPLE_W'(sat_signed(32'(w_sum_r), SAMPLE_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fc  <= '0;
            r_shl <= '0;
            r_shr <= '0;
        end else begin
            if (r_fc == FC_W'(FRAME - 1)) begin
                r_fc <= '0;
            end else begin
                r_fc <= r_fc + FC_W'(1);
            end
            // Shift at the end of each sck period so the next bit
            // appears together with the sck falling edge.
            if (w_tick) begin
                r_shl <= w_sat_l;
                r_shr <= w_sat_r;
            end else if (w_slot_end) begin
                if (w_lrck) begin
                    r_shr <= r_shr << 1;
                end else begin
                    r_shl <= r_shl << 1;
                end
            end
        end
    end

    assign audio_mclk = r_fc[MCLK_DIV_LOG2-1];
    assign audio_sck  = r_fc[SCK_DIV_LOG2-1];
    assign audio_lrck = w_lrck;
    assign frame_tick = w_tick;
    // The left MSB is due in the very cycle it is being loaded,
    // so it is taken straight from the mixer during the tick.
    assign audio_sdin = w_tick ? w_sat_l[SAMPLE_W-1]
                      : (w_lrck ? r_shr[SAMPLE_W-1] : r_shl[SAMPLE_W-1]);

endmodule

// File: tb/tb_poly_speaker.sv
// tb_poly_speaker: randomised and directed bench for poly_speaker with a
// behavioural reference model of the mixer, envelopes and I2S framing.
module tb_poly_speaker;

    localparam int NV    = 4;
    localparam int SW    = 16;
    localparam int DW    = 22;
    localparam int ATK   = 256;
    localparam int REL   = 64;
    localparam int FRAME = 32 * SW;
    localparam int HALF  = 16 * SW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NV*DW-1:0]  note_div = '0;
    logic [NV*(SW-1)-1:0] vol = '0;
    logic [NV-1:0]     gate = '0;
    logic [NV-1:0]     pan_left = '0;
    logic [NV-1:0]     pan_right = '0;
    logic              audio_mclk;
    logic              audio_lrck;
    logic              audio_sck;
    logic              audio_sdin;
    logic              frame_tick;

    poly_speaker #(
        .NUM_VOICES  (NV),
        .SAMPLE_W    (SW),
        .DIV_W       (DW),
        .ATTACK_STEP (ATK),
        .RELEASE_STEP(REL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .note_div  (note_div),
        .vol       (vol),
        .gate      (gate),
        .pan_left  (pan_left),
        .pan_right (pan_right),
        .audio_mclk(audio_mclk),
        .audio_lrck(audio_lrck),
        .audio_sck (audio_sck),
        .audio_sdin(audio_sdin),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int  m_fc;
    int  m_cnt [NV];
    bit  m_ph  [NV];
    int  m_env [NV];
    int  m_samp_l;
    int  m_samp_r;
    bit  rand_on;

    logic [15:0] sh_l;
    logic [15:0] sh_r;
    logic        prev_sdin;
    logic [15:0] cap_l [$];
    logic [15:0] cap_r [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t fc=%0d)",
                     nm, act, exp, $time, m_fc);
        end
    endtask

    function automatic int f_div(input int v);
        return int'(note_div[v*DW +: DW]);
    endfunction

    function automatic int f_vol(input int v);
        return int'(vol[v*(SW-1) +: SW-1]);
    endfunction

    function automatic int model_mix(input logic [NV-1:0] pan);
        int s;
        s = 0;
        for (int v = 0; v < NV; v++) begin
            if (pan[v] && f_div(v) > 1) begin
                s += m_ph[v] ? m_env[v] : -m_env[v];
            end
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    function automatic int iabs(input logic [15:0] x);
        int s;
        s = int'($signed(x));
        return (s < 0) ? -s : s;
    endfunction

    task automatic model_edge();
        int d;
        int tv;
        if (m_fc == 0) begin
            m_samp_l = model_mix(pan_left);
            m_samp_r = model_mix(pan_right);
            for (int v = 0; v < NV; v++) begin
                tv = f_vol(v);
                if (gate[v]) begin
                    if (m_env[v] < tv) begin
                        m_env[v] = (m_env[v] + ATK > tv) ? tv : m_env[v] + ATK;
                    end else begin
                        m_env[v] = tv;
                    end
                end else begin
                    m_env[v] = (m_env[v] > REL) ? m_env[v] - REL : 0;
                end
            end
        end
        for (int v = 0; v < NV; v++) begin
            d = f_div(v);
            if (d <= 1) begin
                m_cnt[v] = 0;
                m_ph[v]  = 1'b0;
            end else if (m_cnt[v] >= d - 1) begin
                m_cnt[v] = 0;
                m_ph[v]  = ~m_ph[v];
            end else begin
                m_cnt[v]++;
            end
        end
        m_fc = (m_fc + 1) % FRAME;
    endtask

    function automatic logic exp_sdin();
        logic [15:0] s;
        int k;
        if (m_fc == 0) begin
            s = 16'(model_mix(pan_left));
            return s[15];
        end
        if (m_fc < HALF) begin
            s = 16'(m_samp_l);
            k = m_fc / 16;
        end else begin
            s = 16'(m_samp_r);
            k = (m_fc - HALF) / 16;
        end
        return s[15-k];
    endfunction

    task automatic set_voice(input int v, input int d, input int vl,
                             input bit g, input bit pl, input bit pr);
        note_div[v*DW +: DW]     = DW'(d);
        vol[v*(SW-1) +: SW-1]    = (SW-1)'(vl);
        gate[v]                  = g;
        pan_left[v]              = pl;
        pan_right[v]             = pr;
    endtask

    task automatic rand_voice(input int v);
        set_voice(v, $urandom_range(0, 40), $urandom_range(0, 32767),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("mclk", audio_mclk, (m_fc >> 1) & 1);
        chk("sck", audio_sck, (m_fc >> 3) & 1);
        chk("lrck", audio_lrck, m_fc >= HALF);
        chk("tick", frame_tick, m_fc == 0);
        chk("sdin", audio_sdin, exp_sdin());
        if (m_fc % 16 != 0) begin
            chk("sdin_edge", audio_sdin, prev_sdin);
        end
        prev_sdin = audio_sdin;
        if (m_fc % 16 == 8) begin
            if (m_fc < HALF) sh_l = {sh_l[14:0], audio_sdin};
            else             sh_r = {sh_r[14:0], audio_sdin};
        end
        if (m_fc == FRAME - 1) begin
            cap_l.push_back(sh_l);
            cap_r.push_back(sh_r);
        end
        if (rand_on && m_fc != 0 && $urandom_range(0, 99) == 0) begin
            rand_voice(int'($urandom_range(0, NV - 1)));
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) step();
    endtask

    task automatic reset_assert();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mclk", audio_mclk, 0);
        chk("rst_sck", audio_sck, 0);
        chk("rst_lrck", audio_lrck, 0);
        chk("rst_sdin", audio_sdin, 0);
        chk("rst_tick", frame_tick, 0);
        for (int v = 0; v < NV; v++) set_voice(v, 4, 0, 0, 0, 0);
    endtask

    task automatic reset_release();
        m_fc = 0;
        for (int v = 0; v < NV; v++) begin
            m_cnt[v] = 0;
            m_ph[v]  = 1'b0;
            m_env[v] = 0;
        end
        m_samp_l  = 0;
        m_samp_r  = 0;
        sh_l      = '0;
        sh_r      = '0;
        prev_sdin = 1'b0;
        cap_l.delete();
        cap_r.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rand_on = 1'b0;

        // Single voice ramp, then release
        reset_assert();
        set_voice(0, 4, 1000, 1, 1, 0);
        reset_release();
        run_frames(6);
        chk("ramp0", iabs(cap_l[0]), 0);
        chk("ramp1", iabs(cap_l[1]), 256);
        chk("ramp2", iabs(cap_l[2]), 512);
        chk("ramp3", iabs(cap_l[3]), 768);
        chk("ramp4", iabs(cap_l[4]), 1000);
        chk("ramp5", iabs(cap_l[5]), 1000);
        chk("ramp_r", cap_r[4], 0);
        chk("model_pin", m_samp_l, -1000);
        set_voice(0, 4, 1000, 0, 1, 0);
        run_frames(19);
        chk("rel0", iabs(cap_l[6]), 1000);
        chk("rel1", iabs(cap_l[7]), 936);
        chk("rel2", iabs(cap_l[8]), 872);
        chk("rel15", iabs(cap_l[21]), 40);
        chk("rel16", iabs(cap_l[22]), 0);
        chk("rel_hold", iabs(cap_l[24]), 0);

        // Saturation: ph alternates every frame with div 512
        repeat (37) step();
        reset_assert();
        for (int v = 0; v < NV; v++) set_voice(v, 512, 32767, 1, 1, 0);
        reset_release();
        run_frames(36);
        chk("sat_exact", cap_l[32], 16'h8000);
        chk("sat_pos", cap_l[33], 16'h7FFF);
        chk("sat_neg", cap_l[34], 16'h8000);
        chk("sat_pos2", cap_l[35], 16'h7FFF);
        chk("sat_r", cap_r[35], 0);

        // Silent dividers
        repeat (100) step();
        reset_assert();
        set_voice(0, 0, 5000, 1, 1, 1);
        set_voice(1, 1, 5000, 1, 1, 1);
        set_voice(2, 4, 300, 1, 1, 0);
        reset_release();
        run_frames(4);
        chk("silent_l", int'($signed(cap_l[3])), -300);
        chk("silent_r", cap_r[3], 0);

        // Serial format: left 0xA5C3, right +1/-1
        repeat (300) step();
        reset_assert();
        set_voice(0, 4, 7700, 1, 1, 0);
        set_voice(1, 4, 7700, 1, 1, 0);
        set_voice(2, 4, 7701, 1, 1, 0);
        set_voice(3, 512, 1, 1, 0, 1);
        reset_release();
        run_frames(33);
        chk("fmt_l", cap_l[31], 16'hA5C3);
        chk("fmt_r", cap_r[31], 16'h0001);
        chk("fmt_r2", cap_r[32], 16'hFFFF);

        // Randomised traffic
        repeat (200) step();
        reset_assert();
        for (int v = 0; v < NV; v++) rand_voice(v);
        reset_release();
        rand_on = 1'b1;
        run_frames(12);
        rand_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poly_speaker.md
# poly_speaker

Parametrised successor to the single-tone speaker path. Mixes `NUM_VOICES` square-wave voices, each with its own divider, volume, gate and per-voice attack/release envelope. The voices are mixed into a saturated stereo pair using per-voice pan masks. The pair is serialised as left-justified I2S with `SAMPLE_W`-bit samples, and the block sits directly between the music/note sequencer and the audio DAC pins.

## Interface
Parameters:
- `NUM_VOICES`, 4: number of tone voices (1..8).
- `SAMPLE_W`, 16: sample width per channel (8..24).
- `DIV_W`, 22: width of each note divider.
- `ATTACK_STEP`, 256: envelope increment per frame while gated.
- `RELEASE_STEP`, 64: envelope decrement per frame while ungated.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `note_div`  in  `NUM_VOICES*DIV_W`  per-voice half-period in clk cycles; voice i occupies bits `[i*DIV_W +: DIV_W]`.
- `vol`  in  `NUM_VOICES*(SAMPLE_W-1)`  per-voice unsigned target amplitude.
- `gate`  in  `NUM_VOICES`  voice i sounding when 1.
- `pan_left`  in  `NUM_VOICES`  voice i contributes to the left channel.
- `pan_right`  in  `NUM_VOICES`  voice i contributes to the right channel.
- `audio_mclk`  out  1  master clock, clk/4.
- `audio_lrck`  out  1  0 = left half, 1 = right half.
- `audio_sck`  out  1  serial clock, clk/16.
- `audio_sdin`  out  1  serial data, MSB first.
- `frame_tick`  out  1  one-cycle pulse at each frame start.

## Operation
- Frame counter `fc` counts 0..`32*SAMPLE_W-1` and wraps.
  - `audio_mclk = fc[1]`, `audio_sck = fc[3]`.
  - `audio_lrck = (fc >= 16*SAMPLE_W)`.
  - `frame_tick = (fc == 0)`.
- Voice phase:
  - Each voice has a counter and a toggle bit `ph`.
  - When the counter reaches `note_div-1`: counter clears and `ph` inverts.
  - `note_div` of 0 or 1: counter and `ph` are held at 0 and the voice contributes 0.
  - `note_div` changes take effect immediately. If the counter is already ≥ the new `note_div-1`, it clears and toggles on the next cycle.
- Envelope `env` (width `SAMPLE_W-1`, unsigned), updated only on `frame_tick`:
  - `gate` = 1 and `env < vol`: `env` becomes `min(env+ATTACK_STEP, vol)`.
  - `gate` = 1 and `env > vol`: `env` becomes `vol`.
  - `gate` = 0: `env` becomes `max(env-RELEASE_STEP, 0)`.
- Voice sample (signed `SAMPLE_W`): `+env` when `ph`=1, `-env` when `ph`=0, 0 when silent.
- Mix per channel:
  - Signed sum over the voices whose pan bit is set, at width `SAMPLE_W+3`.
  - Saturate to [`-2^(SAMPLE_W-1)`, `2^(SAMPLE_W-1)-1`].
- On `frame_tick`, the saturated left and right values are loaded into the shift registers. This uses voice state from the same cycle and env values from before that cycle's update. Samples are held stable for the whole frame.
- Serialisation, left-justified:
  - `audio_sdin` updates when `fc[3:0]==0`, i.e. on the `audio_sck` falling edge.
  - MSB of the left sample is driven at `fc==0`, MSB of the right sample at `fc==16*SAMPLE_W`.
  - Bit k (0 = MSB) of a half occupies sck period k.

## Timing
- Reset (`rst`=0), asynchronous:
  - `fc`, all phase counters, `ph`, `env` and both shift registers clear to 0.
  - All outputs read 0.
- Reset mid-frame aborts the frame. The first frame after release starts at `fc=0` with `frame_tick` on the first clk edge after `rst` rises.
- Input-to-pin latency: a `gate`/`vol` change reaches the pins at the next `frame_tick`. Its envelope effect shows in the sample loaded one frame later.
- `audio_lrck` toggles on `audio_sck` falling edges only.
- Frame rate = clk/(32*`SAMPLE_W`), i.e. 195.3 kHz at 100 MHz with `SAMPLE_W`=16.
- A voice whose `gate` and `vol` both change in the same cycle uses the new values at the next tick.
- `pan_left` = `pan_right` = 0 for a voice: the voice runs its phase and envelope but is inaudible.

## Structure
- Shared package `audio_pkg`: localparams `SCK_DIV_LOG2`=4 and `MCLK_DIV_LOG2`=2, plus a signed saturate function parameterised by width.
- Sub-module `tone_voice`: phase counter, toggle and envelope for one voice. Instantiate it `NUM_VOICES` times via `generate`.
- The mixer, frame counter and serialiser live in the top level `poly_speaker`.

## Test plan
- Reset: assert `rst`=0 mid-frame → all outputs 0 within the same cycle; after release, `frame_tick` fires on the first edge and `sdin` is 0 for the first frame.
- Single voice:
  - Stimulus: `note_div`=4, `vol`=1000, `ATTACK_STEP`=256, gate=1, pan left only.
  - Required response: left samples ramp in magnitude 256, 512, 768, 1000, 1000…; right channel is 0.
  - `ph` toggles every 4 clk.
- Saturation: 4 voices with `vol`=32767, all `ph`=1, all panned left → left sample is `0x7FFF`; all `ph`=0 → `0x8000`.
- Release: gate falls with `env`=1000 and `RELEASE_STEP`=64 → magnitudes decrease 936, 872, …, 40, 0 and hold at 0.
- Silence: `note_div`=0 or 1 with gate=1 and `vol`=5000 → that voice contributes exactly 0 to the mix.
- Serial format: left=`0xA5C3`, right=`0x0001` → `sdin` bits match MSB first; lrck changes at `fc=256`; sdin changes only on sck falling edges.
